// File: rtl/mux_ctrl_pkg.sv
// mux_ctrl_pkg: shared sizes, FSM encoding and one-hot helper for the mux arbiter
package mux_ctrl_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot = '0;
    onehot[i] = 1'b1;
  endfunction
endpackage

// File: rtl/mux4to1.sv
// mux4to1: shared 4:1 datapath mux steered by the arbiter's sel
module mux4to1 #(
  parameter int W = 8
) (
  input  logic [3:0][W-1:0] w,
  input  logic [1:0]        sel,
  output logic [W-1:0]      out
);
  assign out = w[sel];
endmodule

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin picker, first candidate at or after start
module rr_pick4
  import mux_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   start,
  input  logic               excl_en,
  input  logic [SEL_W-1:0]   excl_idx,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);
  logic [NUM_REQ-1:0] cand;
  assign cand = excl_en ? req & ~onehot(excl_idx) : req;
  // scan from the far end inward so the candidate nearest to start is written last
  always_comb begin
    found = 1'b0;
    idx = start;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (cand[start + SEL_W'(k)]) begin
        found = 1'b1;
        idx = start + SEL_W'(k);
      end
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 mux with optional hold limit
module mux4_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               busy
);
  localparam logic [7:0] HOLD_SAT = MAX_HOLD == 0 ? 8'hFF : 8'(MAX_HOLD - 1);
  state_t state, state_n;
  logic [SEL_W-1:0] last, last_n, sel_n, idx, start;
  logic [NUM_REQ-1:0] grant_n;
  logic [7:0] hold_cnt, hold_n;
  logic busy_n, found, take, drop, hold_done;
  assign start = last + 1'b1;
  rr_pick4 u_pick (
    .req      (req),
    .start    (start),
    .excl_en  (state == ST_GRANT),
    .excl_idx (sel),
    .found    (found),
    .idx      (idx)
  );
  assign hold_done = (MAX_HOLD != 0) && (hold_cnt == HOLD_SAT);
  assign take = found && (state == ST_IDLE || !req[sel] || hold_done);
  assign drop = state == ST_GRANT && !req[sel] && !found;
  // next grant: new owner on take, release to idle on drop, otherwise keep and age
  always_comb begin
    state_n = take ? ST_GRANT : drop ? ST_IDLE : state;
    grant_n = take ? onehot(idx) : drop ? '0 : grant;
    sel_n = take ? idx : sel;
    busy_n = take | (busy & ~drop);
    last_n = take ? idx : last;
    hold_n = (take || drop || state == ST_IDLE) ? 8'd0 : (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + 8'd1;
  end
  // state and registered outputs, async reset gives requester 0 top priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      grant <= '0;
      sel <= '0;
      busy <= 1'b0;
      last <= '1;
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      sel <= sel_n;
      busy <= busy_n;
      last <= last_n;
      hold_cnt <= hold_n;
    end
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: scoreboard bench for the arbiter and its shared mux
module tb_mux4_rr_arbiter;
  typedef struct packed {logic which; logic [3:0] g; logic [1:0] s; logic b;} exp_t;
  logic clk, rst;
  logic [3:0] req8, req0, g8, g0;
  logic [1:0] s8, s0;
  logic b8, b0;
  logic [7:0] m8, m0;
  logic [3:0][7:0] wdat;
  exp_t q[$];
  int ncmp, nfail;
  string phase;
  mux4_rr_arbiter #(.MAX_HOLD(8)) u8 (.clk(clk), .rst(rst), .req(req8), .grant(g8), .sel(s8), .busy(b8));
  mux4_rr_arbiter #(.MAX_HOLD(0)) u0 (.clk(clk), .rst(rst), .req(req0), .grant(g0), .sel(s0), .busy(b0));
  mux4to1 #(.W(8)) mx8 (.w(wdat), .sel(s8), .out(m8));
  mux4to1 #(.W(8)) mx0 (.w(wdat), .sel(s0), .out(m0));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  task automatic exp8(input logic [3:0] g, input logic [1:0] s, input logic b);
    q.push_back('{1'b0, g, s, b});
  endtask
  task automatic exp0(input logic [3:0] g, input logic [1:0] s, input logic b);
    q.push_back('{1'b1, g, s, b});
  endtask
  task automatic check_now();
    exp_t e;
    logic [3:0] og;
    logic [1:0] os;
    logic ob;
    logic [7:0] om;
    while (q.size() > 0) begin
      e = q.pop_front();
      og = e.which ? g0 : g8;
      os = e.which ? s0 : s8;
      ob = e.which ? b0 : b8;
      om = e.which ? m0 : m8;
      ncmp++;
      assert ({og, os, ob} === {e.g, e.s, e.b}) else begin
        nfail++;
        $error("FAIL %s dut%0d: got grant=%b sel=%0d busy=%b, expected grant=%b sel=%0d busy=%b", phase, e.which, og, os, ob, e.g, e.s, e.b);
      end
      ncmp++;
      assert (om === wdat[e.s]) else begin
        nfail++;
        $error("FAIL %s mux%0d: got out=%h, expected %h", phase, e.which, om, wdat[e.s]);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask
  initial begin
    ncmp = 0;
    nfail = 0;
    wdat = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    rst = 1'b1;
    req8 = 4'b0000;
    req0 = 4'b0000;
    phase = "reset";
    repeat (2) @(posedge clk);
    #1;
    exp8(4'b0000, 2'd0, 1'b0);
    exp0(4'b0000, 2'd0, 1'b0);
    check_now();
    rst = 1'b0;
    phase = "single_req";
    for (int i = 0; i < 3; i++) begin
      req8 = 4'b0100;
      exp8(4'b0100, 2'd2, 1'b1);
      tick();
    end
    req8 = 4'b0000;
    exp8(4'b0000, 2'd2, 1'b0);
    tick();
    exp8(4'b0000, 2'd2, 1'b0);
    tick();
    phase = "handoff";
    req8 = 4'b0010;
    exp8(4'b0010, 2'd1, 1'b1);
    tick();
    req8 = 4'b1010;
    exp8(4'b0010, 2'd1, 1'b1);
    tick();
    req8 = 4'b1000;
    exp8(4'b1000, 2'd3, 1'b1);
    tick();
    req8 = 4'b0000;
    exp8(4'b0000, 2'd3, 1'b0);
    tick();
    phase = "rotate_hold8";
    req8 = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 8; i++) begin
        exp8(4'b0001 << r, 2'(r), 1'b1);
        tick();
      end
    for (int i = 0; i < 2; i++) begin
      exp8(4'b0001, 2'd0, 1'b1);
      tick();
    end
    req8 = 4'b0000;
    exp8(4'b0000, 2'd0, 1'b0);
    tick();
    phase = "sole_owner";
    req8 = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      exp8(4'b0001, 2'd0, 1'b1);
      tick();
    end
    req8 = 4'b0000;
    exp8(4'b0000, 2'd0, 1'b0);
    tick();
    phase = "async_reset";
    req8 = 4'b1111;
    exp8(4'b0010, 2'd1, 1'b1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    exp8(4'b0000, 2'd0, 1'b0);
    check_now();
    @(negedge clk);
    rst = 1'b0;
    exp8(4'b0001, 2'd0, 1'b1);
    tick();
    phase = "unlimited_hold";
    req8 = 4'b0000;
    tick();
    req0 = 4'b0011;
    for (int i = 0; i < 30; i++) begin
      exp0(4'b0001, 2'd0, 1'b1);
      exp8(4'b0000, 2'd0, 1'b0);
      tick();
    end
    req0 = 4'b0010;
    exp0(4'b0010, 2'd1, 1'b1);
    tick();
    req0 = 4'b0000;
    exp0(4'b0000, 2'd1, 1'b0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
